// File: rtl/video_ram_arbiter.sv
// Character RAM arbiter: display scanout owns phase-0 cycles of each cell,
// the host gets every other cycle. Supports scrolling via a first-row offset.
module video_ram_arbiter #(
  parameter int COLS        = 80,
  parameter int ROWS        = 24,
  parameter int CELL_CLKS   = 16,
  parameter int GLYPH_LINES = 16,
  parameter int AW          = 11
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          hblank,
  input  logic          vblank,
  input  logic [4:0]    first_row,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic          host_ack,
  output logic          host_rvalid,
  output logic [7:0]    host_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata,
  output logic [7:0]    char_code,
  output logic          char_valid,
  output logic [3:0]    glyph_line
);

  localparam int PW = $clog2(CELL_CLKS);
  localparam int CW = $clog2(COLS + 1);
  localparam logic [AW:0] CELLS    = (AW+1)'(COLS * ROWS);
  localparam logic [AW:0] ROW_STEP = (AW+1)'(COLS);

  logic [PW-1:0] phase;
  logic [CW-1:0] col;
  logic [AW-1:0] row_base;
  logic          hb_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    wdata_q;
  logic          rd_disp_q;
  logic          rd_host_q;

  logic          active;
  logic          slot;
  logic          host_go;
  logic [AW:0]   disp_sum;
  logic [AW-1:0] disp_addr;
  logic [AW:0]   next_base;
  logic [AW-1:0] frame_base;

  // clr gates the issue logic so no access reaches RAM while reset is held
  always_comb begin
    active   = ~hblank & ~vblank;
    slot     = ~clr & active & (phase == '0);
    host_go  = ~clr & host_req & ~slot;
    disp_sum = {1'b0, row_base} + (AW+1)'(col);
    if (disp_sum >= CELLS) disp_addr = AW'(disp_sum - CELLS);
    else                   disp_addr = AW'(disp_sum);
    next_base = {1'b0, row_base} + ROW_STEP;
    if (next_base >= CELLS) next_base = '0;
    if (first_row < 5'(ROWS)) frame_base = AW'(first_row) * AW'(COLS);
    else                      frame_base = '0;
  end

  always_comb begin
    ram_addr    = addr_q;
    ram_wdata   = wdata_q;
    ram_we      = 1'b0;
    host_ack    = host_go;
    host_rvalid = rd_host_q;
    host_rdata  = rd_host_q ? ram_rdata : 8'h00;
    if (slot) begin
      ram_addr = disp_addr;
    end else if (host_go) begin
      ram_addr  = host_addr;
      ram_we    = host_we;
      ram_wdata = host_wdata;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      phase      <= '0;
      col        <= '0;
      row_base   <= '0;
      glyph_line <= '0;
      hb_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_disp_q  <= 1'b0;
      rd_host_q  <= 1'b0;
      char_code  <= '0;
      char_valid <= 1'b0;
    end else begin
      hb_q      <= hblank;
      addr_q    <= ram_addr;
      wdata_q   <= ram_wdata;
      rd_disp_q <= slot;
      rd_host_q <= host_go & ~host_we;

      // RAM data for a display slot arrives one cycle later; register it once
      char_valid <= rd_disp_q;
      if (rd_disp_q) char_code <= ram_rdata;

      if (hblank | vblank)                    phase <= '0;
      else if (phase == PW'(CELL_CLKS - 1))   phase <= '0;
      else                                    phase <= phase + 1'b1;

      if (hblank)    col <= '0;
      else if (slot) col <= col + 1'b1;

      if (vblank) begin
        glyph_line <= '0;
        row_base   <= frame_base;
      end else if (hblank & ~hb_q) begin
        if (glyph_line == 4'(GLYPH_LINES - 1)) begin
          glyph_line <= '0;
          row_base   <= AW'(next_base);
        end else begin
          glyph_line <= glyph_line + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_ram_arbiter.sv
// Bench for video_ram_arbiter: RAM model plus a spec-level model of fetch
// addresses, host grants and read-back data.
module tb_video_ram_arbiter;

  localparam int COLS  = 80;
  localparam int ROWS  = 24;
  localparam int CELLS = COLS * ROWS;
  localparam int LINE  = 1280;
  localparam int HB    = 40;

  logic        clk = 1'b0;
  logic        clr;
  logic        hblank, vblank;
  logic [4:0]  first_row;
  logic        host_req, host_we;
  logic [10:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack, host_rvalid;
  logic [7:0]  host_rdata;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  char_code;
  logic        char_valid;
  logic [3:0]  glyph_line;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mem     [0:2047];
  bit          wr_flag [0:2047];
  logic [7:0]  ref_mem [0:2047];

  logic [10:0] obs_addr [COLS];
  logic [7:0]  obs_char [COLS];
  int          obs_cv;
  int          obs_we;

  always #5 clk = ~clk;

  video_ram_arbiter dut (
    .clk(clk), .clr(clr), .hblank(hblank), .vblank(vblank),
    .first_row(first_row), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .char_code(char_code), .char_valid(char_valid), .glyph_line(glyph_line)
  );

  // single-port synchronous RAM, preloaded with each cell's low address byte
  always @(posedge clk) begin
    ram_rdata <= wr_flag[ram_addr] ? mem[ram_addr] : ram_addr[7:0];
    if (ram_we) begin
      mem[ram_addr]     <= ram_wdata;
      wr_flag[ram_addr] <= 1'b1;
    end
  end

  // text row shown on scanline n of a frame whose top row is 'top'
  function automatic int exp_addr(int top, int n, int c);
    return (((top + n / 16) % ROWS) * COLS + c) % CELLS;
  endfunction

  function automatic int top_row(int fr);
    return (fr < ROWS) ? fr : 0;
  endfunction

  task automatic drive_vblank();
    host_req = 1'b0;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; hblank = 1'b1; vblank = 1'b1; end
    for (int i = 0; i < 5; i++)  begin @(posedge clk); #1; hblank = 1'b1; vblank = 1'b0; end
  endtask

  // one visible line followed by horizontal blanking; records observations only
  task automatic drive_line();
    obs_cv = 0;
    obs_we = 0;
    host_req = 1'b0;
    for (int i = 0; i < LINE + HB; i++) begin
      @(posedge clk); #1;
      hblank = (i >= LINE);
      vblank = 1'b0;
      @(negedge clk);
      if (i < LINE && i % 16 == 0) obs_addr[i / 16] = ram_addr;
      if (char_valid) begin
        if (obs_cv < COLS) obs_char[obs_cv] = char_code;
        obs_cv++;
      end
      if (ram_we) obs_we++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_cmp++; if (glyph_line !== 4'd0) begin n_bad++; $display("FAIL reset_glyph got %0d want 0", glyph_line); end
    n_cmp++; if (host_ack !== 1'b0)   begin n_bad++; $display("FAIL reset_ack got %0b want 0", host_ack); end
    n_cmp++; if (char_valid !== 1'b0) begin n_bad++; $display("FAIL reset_cv got %0b want 0", char_valid); end
    n_cmp++; if (ram_we !== 1'b0)     begin n_bad++; $display("FAIL reset_we got %0b want 0", ram_we); end
    n_cmp++; if (ram_addr !== 11'd0)  begin n_bad++; $display("FAIL reset_addr got %0d want 0", ram_addr); end
    @(posedge clk); #1; clr = 1'b0;
    drive_vblank();
    drive_line();
    drive_line();
    n_cmp++; if (glyph_line !== 4'd2) begin n_bad++; $display("FAIL pre_clr_glyph got %0d want 2", glyph_line); end
    for (int i = 0; i < 50; i++) begin @(posedge clk); #1; hblank = 1'b0; vblank = 1'b0; end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      clr = 1'b1; host_req = 1'b1; host_we = 1'b1; host_addr = 11'd5; host_wdata = 8'hEE;
      @(negedge clk);
      n_cmp++; if (host_ack !== 1'b0)    begin n_bad++; $display("FAIL clr_ack got %0b want 0", host_ack); end
      n_cmp++; if (ram_we !== 1'b0)      begin n_bad++; $display("FAIL clr_we got %0b want 0", ram_we); end
      n_cmp++; if (char_valid !== 1'b0)  begin n_bad++; $display("FAIL clr_cv got %0b want 0", char_valid); end
      n_cmp++; if (glyph_line !== 4'd0)  begin n_bad++; $display("FAIL clr_glyph got %0d want 0", glyph_line); end
      n_cmp++; if (host_rvalid !== 1'b0) begin n_bad++; $display("FAIL clr_rvalid got %0b want 0", host_rvalid); end
    end
    @(posedge clk); #1; host_req = 1'b0; hblank = 1'b1; vblank = 1'b1; first_row = 5'd7;
    @(posedge clk); #1; clr = 1'b0;
    drive_vblank();
    drive_line();
    n_cmp++; if (obs_addr[0] !== 11'd560)  begin n_bad++; $display("FAIL post_clr_first_addr got %0d want 560", obs_addr[0]); end
    n_cmp++; if (obs_addr[79] !== 11'd639) begin n_bad++; $display("FAIL post_clr_last_addr got %0d want 639", obs_addr[79]); end
    n_cmp++; if (obs_we !== 0)             begin n_bad++; $display("FAIL dropped_req_we got %0d want 0", obs_we); end
    n_cmp++; if (obs_cv !== COLS)          begin n_bad++; $display("FAIL post_clr_cv_count got %0d want %0d", obs_cv, COLS); end
  endtask

  // random host traffic interleaved with two visible lines of first_row=0
  task automatic test_line_fetch();
    logic [7:0] cq[$];
    logic       acked, rd_pend, slot, exp_ack, cv_exp;
    logic [7:0] rd_exp, ec;
    int         ea;
    first_row = 5'd0;
    drive_vblank();
    acked = 1'b1;
    rd_pend = 1'b0;
    rd_exp = 8'h00;
    for (int ln = 0; ln < 2; ln++) begin
      for (int i = 0; i < LINE + HB; i++) begin
        @(posedge clk); #1;
        hblank = (i >= LINE);
        vblank = 1'b0;
        if (acked || !host_req) begin
          host_req   = ($urandom % 3 != 0);
          host_we    = 1'($urandom % 2);
          host_addr  = 11'($urandom_range(0, 2047));
          host_wdata = 8'($urandom);
        end
        @(negedge clk);
        slot    = (i < LINE) && (i % 16 == 0);
        exp_ack = host_req && !slot;
        cv_exp  = (i < LINE) && (i % 16 == 2);
        n_cmp++; if (host_ack !== exp_ack) begin n_bad++; $display("FAIL lf_ack line %0d cyc %0d got %0b want %0b", ln, i, host_ack, exp_ack); end
        if (slot) begin
          ea = exp_addr(0, ln, i / 16);
          n_cmp++; if (ram_addr !== 11'(ea)) begin n_bad++; $display("FAIL lf_slot_addr cyc %0d got %0d want %0d", i, ram_addr, ea); end
          n_cmp++; if (ram_we !== 1'b0)      begin n_bad++; $display("FAIL lf_slot_we cyc %0d got %0b want 0", i, ram_we); end
          cq.push_back(ref_mem[ea]);
        end
        n_cmp++; if (char_valid !== cv_exp) begin n_bad++; $display("FAIL lf_char_valid cyc %0d got %0b want %0b", i, char_valid, cv_exp); end
        if (cv_exp && cq.size() > 0) begin
          ec = cq.pop_front();
          n_cmp++; if (char_code !== ec) begin n_bad++; $display("FAIL lf_char_code cyc %0d got %0h want %0h", i, char_code, ec); end
        end
        n_cmp++; if (host_rvalid !== rd_pend) begin n_bad++; $display("FAIL lf_rvalid cyc %0d got %0b want %0b", i, host_rvalid, rd_pend); end
        if (rd_pend) begin
          n_cmp++; if (host_rdata !== rd_exp) begin n_bad++; $display("FAIL lf_rdata cyc %0d got %0h want %0h", i, host_rdata, rd_exp); end
        end
        rd_pend = 1'b0;
        if (exp_ack) begin
          n_cmp++; if (ram_addr !== host_addr) begin n_bad++; $display("FAIL lf_host_addr cyc %0d got %0d want %0d", i, ram_addr, host_addr); end
          n_cmp++; if (ram_we !== host_we)     begin n_bad++; $display("FAIL lf_host_we cyc %0d got %0b want %0b", i, ram_we, host_we); end
          if (host_we) begin
            n_cmp++; if (ram_wdata !== host_wdata) begin n_bad++; $display("FAIL lf_host_wdata cyc %0d got %0h want %0h", i, ram_wdata, host_wdata); end
            ref_mem[host_addr] = host_wdata;
          end else begin
            rd_pend = 1'b1;
            rd_exp  = ref_mem[host_addr];
          end
        end
        acked = exp_ack;
      end
    end
    @(posedge clk); #1; host_req = 1'b0;
  endtask

  task automatic test_host_collision();
    int we_cnt;
    first_row = 5'd0;
    drive_vblank();
    we_cnt = 0;
    for (int i = 0; i < LINE + HB; i++) begin
      @(posedge clk); #1;
      hblank     = (i >= LINE);
      vblank     = 1'b0;
      host_req   = (i == 16 || i == 17 || i == 32 || i == 33);
      host_we    = (i < 32);
      host_addr  = 11'd100;
      host_wdata = 8'h41;
      @(negedge clk);
      if (ram_we) we_cnt++;
      if (i == 16) begin
        n_cmp++; if (host_ack !== 1'b0) begin n_bad++; $display("FAIL col_ack_on_slot got %0b want 0", host_ack); end
        n_cmp++; if (ram_addr !== 11'd1) begin n_bad++; $display("FAIL col_slot_addr got %0d want 1", ram_addr); end
      end
      if (i == 17) begin
        n_cmp++; if (host_ack !== 1'b1)    begin n_bad++; $display("FAIL col_wr_ack got %0b want 1", host_ack); end
        n_cmp++; if (ram_we !== 1'b1)      begin n_bad++; $display("FAIL col_wr_we got %0b want 1", ram_we); end
        n_cmp++; if (ram_addr !== 11'd100) begin n_bad++; $display("FAIL col_wr_addr got %0d want 100", ram_addr); end
        n_cmp++; if (ram_wdata !== 8'h41)  begin n_bad++; $display("FAIL col_wr_data got %0h want 41", ram_wdata); end
      end
      if (i == 18) begin
        n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL col_we_after got %0b want 0", ram_we); end
      end
      if (i == 32) begin
        n_cmp++; if (host_ack !== 1'b0) begin n_bad++; $display("FAIL col_rd_ack_on_slot got %0b want 0", host_ack); end
      end
      if (i == 33) begin
        n_cmp++; if (host_ack !== 1'b1) begin n_bad++; $display("FAIL col_rd_ack got %0b want 1", host_ack); end
        n_cmp++; if (ram_we !== 1'b0)   begin n_bad++; $display("FAIL col_rd_we got %0b want 0", ram_we); end
      end
      if (i == 34) begin
        n_cmp++; if (host_rvalid !== 1'b1) begin n_bad++; $display("FAIL col_rvalid got %0b want 1", host_rvalid); end
        n_cmp++; if (host_rdata !== 8'h41) begin n_bad++; $display("FAIL col_rdata got %0h want 41", host_rdata); end
        n_cmp++; if (char_valid !== 1'b1)  begin n_bad++; $display("FAIL col_char_valid got %0b want 1", char_valid); end
      end
      if (i == 35) begin
        n_cmp++; if (host_rvalid !== 1'b0) begin n_bad++; $display("FAIL col_rvalid_after got %0b want 0", host_rvalid); end
      end
    end
    ref_mem[100] = 8'h41;
    n_cmp++; if (we_cnt !== 1) begin n_bad++; $display("FAIL col_we_count got %0d want 1", we_cnt); end
  endtask

  task automatic test_blank_throughput();
    logic [10:0] wa [50];
    logic [7:0]  rexp;
    int          acks;
    acks = 0;
    rexp = 8'h00;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      hblank = 1'b1; vblank = 1'b0;
      host_req = 1'b1; host_we = 1'b1;
      host_addr = 11'($urandom_range(0, CELLS - 1));
      host_wdata = 8'($urandom);
      wa[k] = host_addr;
      @(negedge clk);
      if (host_ack) acks++;
      n_cmp++; if (ram_addr !== host_addr)   begin n_bad++; $display("FAIL bt_addr k %0d got %0d want %0d", k, ram_addr, host_addr); end
      n_cmp++; if (ram_wdata !== host_wdata) begin n_bad++; $display("FAIL bt_wdata k %0d got %0h want %0h", k, ram_wdata, host_wdata); end
      ref_mem[host_addr] = host_wdata;
    end
    n_cmp++; if (acks !== 50) begin n_bad++; $display("FAIL bt_ack_count got %0d want 50", acks); end
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      host_req = (j < 5); host_we = 1'b0;
      if (j < 5) host_addr = wa[45 + j];
      @(negedge clk);
      if (j > 0) begin
        n_cmp++; if (host_rvalid !== 1'b1) begin n_bad++; $display("FAIL bt_rvalid j %0d got %0b want 1", j, host_rvalid); end
        n_cmp++; if (host_rdata !== rexp)  begin n_bad++; $display("FAIL bt_rdata j %0d got %0h want %0h", j, host_rdata, rexp); end
      end
      if (j < 5) begin
        n_cmp++; if (host_ack !== 1'b1) begin n_bad++; $display("FAIL bt_rd_ack j %0d got %0b want 1", j, host_ack); end
        rexp = ref_mem[wa[45 + j]];
      end
    end
  endtask

  task automatic test_row_advance();
    int ea;
    first_row = 5'd0;
    drive_vblank();
    for (int ln = 0; ln < 17; ln++) begin
      drive_line();
      n_cmp++; if (glyph_line !== 4'((ln + 1) % 16)) begin n_bad++; $display("FAIL ra_glyph line %0d got %0d want %0d", ln, glyph_line, (ln + 1) % 16); end
      n_cmp++; if (obs_cv !== COLS) begin n_bad++; $display("FAIL ra_cv_count line %0d got %0d want %0d", ln, obs_cv, COLS); end
      if (ln == 0 || ln == 16) begin
        for (int c = 0; c < COLS; c++) begin
          ea = exp_addr(0, ln, c);
          n_cmp++; if (obs_addr[c] !== 11'(ea))     begin n_bad++; $display("FAIL ra_addr line %0d col %0d got %0d want %0d", ln, c, obs_addr[c], ea); end
          n_cmp++; if (obs_char[c] !== ref_mem[ea]) begin n_bad++; $display("FAIL ra_char line %0d col %0d got %0h want %0h", ln, c, obs_char[c], ref_mem[ea]); end
        end
      end
    end
  endtask

  task automatic test_scrolling();
    int top, ea;
    first_row = 5'd23;
    top = top_row(23);
    drive_vblank();
    for (int ln = 0; ln < 17; ln++) begin
      if (ln == 3) first_row = 5'd5;
      drive_line();
      if (ln == 0 || ln == 8 || ln == 16) begin
        for (int c = 0; c < COLS; c++) begin
          ea = exp_addr(top, ln, c);
          n_cmp++; if (obs_addr[c] !== 11'(ea)) begin n_bad++; $display("FAIL sc_addr line %0d col %0d got %0d want %0d", ln, c, obs_addr[c], ea); end
        end
      end
    end
    top = top_row(5);
    drive_vblank();
    drive_line();
    for (int c = 0; c < COLS; c++) begin
      ea = exp_addr(top, 0, c);
      n_cmp++; if (obs_addr[c] !== 11'(ea)) begin n_bad++; $display("FAIL sc_new_top col %0d got %0d want %0d", c, obs_addr[c], ea); end
    end
    first_row = 5'd30;
    top = top_row(30);
    drive_vblank();
    drive_line();
    for (int c = 0; c < COLS; c += 8) begin
      ea = exp_addr(top, 0, c);
      n_cmp++; if (obs_addr[c] !== 11'(ea)) begin n_bad++; $display("FAIL sc_bad_row col %0d got %0d want %0d", c, obs_addr[c], ea); end
    end
  endtask

  initial begin
    clr = 1'b1;
    hblank = 1'b1; vblank = 1'b1; first_row = 5'd0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    for (int a = 0; a < 2048; a++) ref_mem[a] = 8'(a);
    test_reset();
    test_line_fetch();
    test_host_collision();
    test_blank_throughput();
    test_row_advance();
    test_scrolling();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
